// File: rtl/rv32_imm_pkg.sv
// Shared definitions for the RV32I immediate generator: opcodes, immediate
// format encodings and the immediate assembly function.
package rv32_imm_pkg;

  localparam int XLEN = 32;

  // Major opcodes, inst[6:0]
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Immediate format, as driven on the imm_type port
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  // Assemble the sign-extended immediate of the given format. Shift-immediates
  // take the plain I form: shamt lands in [4:0] and funct7 stays in the upper bits.
  function automatic logic [31:0] sext_imm(input logic [31:0] inst, input imm_type_e t);
    logic [31:0] imm;
    imm = 32'h0;
    case (t)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/rv32_imm_generator_decoder.sv
// Opcode classifier: maps inst[6:0] to the immediate format. funct3/funct7
// play no part; unknown opcodes (R-type included) decode to IMM_NONE.
module imm_type_decoder
  import rv32_imm_pkg::*;
(
  input  logic [6:0] i_opcode,
  output imm_type_e  o_imm_type
);

  // Opcode to format lookup
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    o_imm_type = IMM_NONE;
    case (i_opcode)
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: o_imm_type = IMM_I;
      OPC_STORE:                                 o_imm_type = IMM_S;
      OPC_BRANCH:                                o_imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC:                        o_imm_type = IMM_U;
      OPC_JAL:                                   o_imm_type = IMM_J;
      default:                                   o_imm_type = IMM_NONE;
    endcase
  end

endmodule

// File: rtl/rv32_imm_generator.sv
// RV32I immediate generator for the decode stage. Emits the sign-extended
// immediate, its format and a valid flag.
// Build option IMM_GEN_REG_OUT_EN: when defined, all outputs are registered
// (1-cycle latency, async clear on rst_n); otherwise purely combinational
// and clk/rst_n are unused.
module rv32_imm_generator
  import rv32_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] out,
  output logic [2:0]      imm_type,
  output logic            imm_valid
);

  imm_type_e       w_type;
  logic [XLEN-1:0] w_imm;
  logic            w_valid;

  imm_type_decoder u_decoder (
    .i_opcode   (inst[6:0]),
    .o_imm_type (w_type)
  );

  // Select the immediate form for the decoded format
  always_comb begin
    w_imm   = sext_imm(inst, w_type);
    w_valid = (w_type != IMM_NONE);
  end

`ifdef IMM_GEN_REG_OUT_EN
  logic [XLEN-1:0] r_out;
  imm_type_e       r_type;
  logic            r_valid;

  // Output register, cleared asynchronously while rst_n is low
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    if (!rst_n) begin
      r_out   <= '0;
      r_type  <= IMM_NONE;
      r_valid <= 1'b0;
    end else begin
      r_out   <= w_imm;
      r_type  <= w_type;
      r_valid <= w_valid;
    end
  end

  assign out       = r_out;
  assign imm_type  = r_type;
  assign imm_valid = r_valid;
`else
  // Clock and reset have no role in the combinational build
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk ^ rst_n;

  assign out       = w_imm;
  assign imm_type  = w_type;
  assign imm_valid = w_valid;
`endif

endmodule

// File: tb/tb_rv32_imm_generator.sv
// Directed self-checking bench for rv32_imm_generator. Exercises the
// combinational build by default, the registered build when
// IMM_GEN_REG_OUT_EN is defined.
module tb_rv32_imm_generator;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic [31:0] out;
  logic [2:0]  imm_type;
  logic        imm_valid;

  int n_cmp = 0;
  int n_mis = 0;

  rv32_imm_generator #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst      (inst),
    .out       (out),
    .imm_type  (imm_type),
    .imm_valid (imm_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifndef IMM_GEN_REG_OUT_EN
  // R-type, zero word and an all-ones (unlisted) opcode all decode to NONE
  task automatic test_none();
    logic [31:0] v_inst;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       v_inst = 32'h01e50f33;
        1:       v_inst = 32'h00000000;
        default: v_inst = 32'hffffffff;
      endcase
      inst = v_inst;
      #1;
      n_cmp++;
      if (out !== 32'h0) begin
        n_mis++;
        $display("FAIL none[%0d] out: got %h want 00000000", k, out);
      end
      n_cmp++;
      if (imm_type !== T_NONE) begin
        n_mis++;
        $display("FAIL none[%0d] imm_type: got %0d want %0d", k, imm_type, T_NONE);
      end
      n_cmp++;
      if (imm_valid !== 1'b0) begin
        n_mis++;
        $display("FAIL none[%0d] imm_valid: got %b want 0", k, imm_valid);
      end
    end
  endtask

  // I-format: load, op-imm (incl. shift with funct7), jalr, system, bad funct3
  task automatic test_i_type();
    logic [31:0] v_inst, v_out;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0:       begin v_inst = 32'h00850f03; v_out = 32'h00000008; end // lb x30,8(x10)
        1:       begin v_inst = 32'hfff00093; v_out = 32'hffffffff; end // addi x1,x0,-1
        2:       begin v_inst = 32'h4030d093; v_out = 32'h00000403; end // srai x1,x1,3
        3:       begin v_inst = 32'h00008067; v_out = 32'h00000000; end // jalr x0,0(x1)
        4:       begin v_inst = 32'h00000073; v_out = 32'h00000000; end // ecall
        default: begin v_inst = 32'h7ff0f003; v_out = 32'h000007ff; end // load, funct3=111
      endcase
      inst = v_inst;
      #1;
      n_cmp++;
      if (out !== v_out) begin
        n_mis++;
        $display("FAIL i_type[%0d] out: got %h want %h", k, out, v_out);
      end
      n_cmp++;
      if (imm_type !== T_I) begin
        n_mis++;
        $display("FAIL i_type[%0d] imm_type: got %0d want %0d", k, imm_type, T_I);
      end
      n_cmp++;
      if (imm_valid !== 1'b1) begin
        n_mis++;
        $display("FAIL i_type[%0d] imm_valid: got %b want 1", k, imm_valid);
      end
    end
  endtask

  // S, B, U and J formats with positive and negative immediates
  task automatic test_sbuj();
    logic [31:0] v_inst, v_out;
    logic [2:0]  v_type;
    for (int k = 0; k < 7; k++) begin
      case (k)
        0:       begin v_inst = 32'h01ff2523; v_out = 32'h0000000a; v_type = T_S; end // sw x31,10(x30)
        1:       begin v_inst = 32'hfe000fa3; v_out = 32'hffffffff; v_type = T_S; end // sb x0,-1(x0)
        2:       begin v_inst = 32'h01ff2563; v_out = 32'h0000000a; v_type = T_B; end // branch +10
        3:       begin v_inst = 32'hfe000ee3; v_out = 32'hfffffffc; v_type = T_B; end // beq -4
        4:       begin v_inst = 32'h123450b7; v_out = 32'h12345000; v_type = T_U; end // lui
        5:       begin v_inst = 32'hfffff017; v_out = 32'hfffff000; v_type = T_U; end // auipc
        default: begin v_inst = 32'hffdff06f; v_out = 32'hfffffffc; v_type = T_J; end // jal x0,-4
      endcase
      inst = v_inst;
      #1;
      n_cmp++;
      if (out !== v_out) begin
        n_mis++;
        $display("FAIL sbuj[%0d] out: got %h want %h", k, out, v_out);
      end
      n_cmp++;
      if (imm_type !== v_type) begin
        n_mis++;
        $display("FAIL sbuj[%0d] imm_type: got %0d want %0d", k, imm_type, v_type);
      end
      n_cmp++;
      if (imm_valid !== 1'b1) begin
        n_mis++;
        $display("FAIL sbuj[%0d] imm_valid: got %b want 1", k, imm_valid);
      end
    end
  endtask

  // Combinational outputs ignore rst_n entirely
  task automatic test_reset_ignored();
    rst_n = 1'b0;
    inst  = 32'h123450b7;
    #1;
    n_cmp++;
    if (out !== 32'h12345000) begin
      n_mis++;
      $display("FAIL reset_ignored out: got %h want 12345000", out);
    end
    n_cmp++;
    if (imm_type !== T_U) begin
      n_mis++;
      $display("FAIL reset_ignored imm_type: got %0d want %0d", imm_type, T_U);
    end
    rst_n = 1'b1;
  endtask
`else
  // Outputs held at zero while reset is asserted, whatever inst is
  task automatic test_reset();
    logic [31:0] v_inst;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      v_inst = (k == 0) ? 32'hfff00093 : 32'h123450b7;
      inst = v_inst;
      @(negedge clk);
      n_cmp++;
      if (out !== 32'h0) begin
        n_mis++;
        $display("FAIL reset[%0d] out: got %h want 00000000", k, out);
      end
      n_cmp++;
      if (imm_type !== T_NONE) begin
        n_mis++;
        $display("FAIL reset[%0d] imm_type: got %0d want %0d", k, imm_type, T_NONE);
      end
      n_cmp++;
      if (imm_valid !== 1'b0) begin
        n_mis++;
        $display("FAIL reset[%0d] imm_valid: got %b want 0", k, imm_valid);
      end
    end
  endtask

  // After release, each output reflects the inst present at the previous posedge
  task automatic test_latency();
    @(negedge clk);
    rst_n = 1'b1;
    inst  = 32'h123450b7;
    #1;
    n_cmp++;
    if (out !== 32'h0) begin
      n_mis++;
      $display("FAIL latency pre-capture out: got %h want 00000000", out);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out !== 32'h12345000) begin
      n_mis++;
      $display("FAIL latency first out: got %h want 12345000", out);
    end
    n_cmp++;
    if (imm_type !== T_U || imm_valid !== 1'b1) begin
      n_mis++;
      $display("FAIL latency first type/valid: got %0d/%b want %0d/1", imm_type, imm_valid, T_U);
    end
    inst = 32'hfff00093;
    #1;
    n_cmp++;
    if (out !== 32'h12345000) begin
      n_mis++;
      $display("FAIL latency hold out: got %h want 12345000", out);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out !== 32'hffffffff || imm_type !== T_I) begin
      n_mis++;
      $display("FAIL latency second out/type: got %h/%0d want ffffffff/%0d", out, imm_type, T_I);
    end
  endtask

  // Reset asserted between clock edges clears outputs at once
  task automatic test_async_clear();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out !== 32'h0 || imm_type !== T_NONE || imm_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL async_clear: got %h/%0d/%b want 00000000/0/0", out, imm_type, imm_valid);
    end
    #2;
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    rst_n = 1'b1;
    inst  = 32'h0;
`ifndef IMM_GEN_REG_OUT_EN
    #2;
    test_none();
    test_i_type();
    test_sbuj();
    test_reset_ignored();
`else
    test_reset();
    test_latency();
    test_async_clear();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
